// File: rtl/narrow_pkg.sv
// Shared types and constants for the 32-to-16 narrowing block.
package narrow_pkg;

  localparam int unsigned DW_IN  = 32;
  localparam int unsigned DW_OUT = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } state_t;

  localparam logic [DW_OUT-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DW_OUT-1:0] SAT_MIN = 16'h8000;

  localparam logic MODE_NARROW = 1'b0;
  localparam logic MODE_SPLIT  = 1'b1;

  // One output beat as held in the output register.
  typedef struct packed {
    logic [DW_OUT-1:0] data;
    logic              ovf;
    logic              last;
  } beat_t;

endpackage

// File: rtl/narrow_32_to_16_sat.sv
// Combinational signed 32->16 narrowing with optional saturation.
module sat_32_to_16
  import narrow_pkg::*;
(
  input  logic [DW_IN-1:0]  in,
  input  logic              sat,
  output logic [DW_OUT-1:0] out,
  output logic              ovf
);

  logic in_range;

  // Representable iff the top 17 bits are a pure sign extension.
  assign in_range = (&in[DW_IN-1:DW_OUT-1]) | ~(|in[DW_IN-1:DW_OUT-1]);

  always_comb begin
    out = in[DW_OUT-1:0];
    ovf = ~in_range;
    if (!in_range && sat) begin
      out = in[DW_IN-1] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule

// File: rtl/narrow_32_to_16.sv
// Stream narrower: one 32-bit word in, one (narrow) or two (split) halfwords out.
// Optional overflow beat counter enabled by NARROW_OVF_COUNT_EN.
module narrow_32_to_16
  import narrow_pkg::*;
#(
  parameter bit SAT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW_IN-1:0]  in_data,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW_OUT-1:0] out_data,
  output logic              out_ovf,
  output logic              out_last
`ifdef NARROW_OVF_COUNT_EN
  ,
  output logic [15:0]       ovf_count
`endif
);

  state_t            state, state_nxt;
  beat_t             beat_q, beat_nxt, load_beat;
  logic              valid_nxt;
  logic [DW_OUT-1:0] hi_q, hi_nxt;
  logic [DW_OUT-1:0] sat_out;
  logic              sat_ovf;
  logic              accept, take;

  sat_32_to_16 u_sat (
    .in  (in_data),
    .sat (SAT),
    .out (sat_out),
    .ovf (sat_ovf)
  );

  assign take     = out_valid && out_ready;
  assign in_ready = !rst && (state == IDLE || (out_ready && out_last && out_valid));
  assign accept   = in_valid && in_ready;

  assign out_data = beat_q.data;
  assign out_ovf  = beat_q.ovf;
  assign out_last = beat_q.last;

  // First (or only) beat of a freshly accepted word.
  always_comb begin
    if (in_mode == MODE_SPLIT) begin
      load_beat = '{data: in_data[DW_OUT-1:0], ovf: 1'b0, last: 1'b0};
    end else begin
      load_beat = '{data: sat_out, ovf: sat_ovf, last: 1'b1};
    end
  end

  // Next-state and next-output logic; a new accept overrides the drain path.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_q;
    valid_nxt = out_valid;
    hi_nxt    = hi_q;
    case (state)
      IDLE: ;
      SEND_LO: begin
        if (take) begin
          if (beat_q.last) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
          end else begin
            state_nxt = SEND_HI;
            beat_nxt  = '{data: hi_q, ovf: 1'b0, last: 1'b1};
          end
        end
      end
      SEND_HI: begin
        if (take) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase
    if (accept) begin
      state_nxt = SEND_LO;
      valid_nxt = 1'b1;
      beat_nxt  = load_beat;
      if (in_mode == MODE_SPLIT) begin
        hi_nxt = in_data[DW_IN-1:DW_OUT];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      beat_q    <= '0;
      hi_q      <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= valid_nxt;
      beat_q    <= beat_nxt;
      hi_q      <= hi_nxt;
    end
  end

`ifdef NARROW_OVF_COUNT_EN
  // Saturating count of delivered overflow beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_count <= '0;
    end else if (take && out_ovf && ovf_count != 16'hFFFF) begin
      ovf_count <= ovf_count + 16'd1;
    end
  end
`endif

endmodule
